// File: rtl/n_port_alloc_if.sv
// Port bundle for the north output allocator: per-input head-flit info,
// downstream credit return, and the allocator's grant/select/status outputs.
interface n_port_alloc_if #(
    parameter int CNT_W = 3
);
    logic [2:0]       s_nexthop_addr_i;
    logic [2:0]       w_nexthop_addr_i;
    logic [2:0]       e_nexthop_addr_i;
    logic [2:0]       l_nexthop_addr_i;
    logic             s_valid_i;
    logic             w_valid_i;
    logic             e_valid_i;
    logic             l_valid_i;
    logic             s_tail_i;
    logic             w_tail_i;
    logic             e_tail_i;
    logic             l_tail_i;
    logic             credit_return_i;

    logic [3:0]       alloc_grant_o;
    logic [2:0]       xbar_sel_o;
    logic             flit_fire_o;
    logic             rr_change_order_o;
    logic [CNT_W-1:0] credit_cnt_o;
    logic             credit_err_o;
    logic             busy_o;
    logic             wdog_timeout_o;

    modport master (
        output s_nexthop_addr_i, w_nexthop_addr_i, e_nexthop_addr_i, l_nexthop_addr_i,
        output s_valid_i, w_valid_i, e_valid_i, l_valid_i,
        output s_tail_i, w_tail_i, e_tail_i, l_tail_i,
        output credit_return_i,
        input  alloc_grant_o, xbar_sel_o, flit_fire_o, rr_change_order_o,
        input  credit_cnt_o, credit_err_o, busy_o, wdog_timeout_o
    );

    modport slave (
        input  s_nexthop_addr_i, w_nexthop_addr_i, e_nexthop_addr_i, l_nexthop_addr_i,
        input  s_valid_i, w_valid_i, e_valid_i, l_valid_i,
        input  s_tail_i, w_tail_i, e_tail_i, l_tail_i,
        input  credit_return_i,
        output alloc_grant_o, xbar_sel_o, flit_fire_o, rr_change_order_o,
        output credit_cnt_o, credit_err_o, busy_o, wdog_timeout_o
    );
endinterface

// File: rtl/n_port_alloc_ctrl.sv
// North output port allocator: round-robin packet arbitration, path lock until tail,
// downstream credit tracking. Optional stall watchdog built with N_ALLOC_WATCHDOG_EN.
//
//   state | meaning
//   IDLE  | no owner; pick a north-bound requester when credits are available
//   LOCK  | path locked to owner; flits fire while owner valid and credits > 0
module n_port_alloc_ctrl #(
    parameter logic [2:0] N_ADDR       = 3'b000,
    parameter int         CREDIT_DEPTH = 4,
    parameter int         CNT_W        = 3,
    parameter int         WDOG_CYCLES  = 16
) (
    input logic           clk,
    input logic           reset,
    n_port_alloc_if.slave bus
);
    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] LOCK = 1'b1;

    localparam logic [CNT_W-1:0] CREDIT_MAX = CNT_W'(CREDIT_DEPTH);

    logic [0:0]       state;
    logic [1:0]       owner;
    logic [1:0]       ptr;
    logic             rr_pulse;
    logic [CNT_W-1:0] credit_cnt;
    logic             credit_err;

    logic [3:0] req;
    logic [3:0] valid_vec;
    logic [3:0] tail_vec;
    logic [1:0] winner;
    logic       winner_found;
    logic [1:0] idx;
    logic       credit_nz;
    logic       fire;
    logic       wdog_expire;
    logic       release_now;

    // index 0=S, 1=W, 2=E, 3=L
    assign valid_vec = {bus.l_valid_i, bus.e_valid_i, bus.w_valid_i, bus.s_valid_i};
    assign tail_vec  = {bus.l_tail_i, bus.e_tail_i, bus.w_tail_i, bus.s_tail_i};
    assign req[0]    = bus.s_valid_i && (bus.s_nexthop_addr_i == N_ADDR);
    assign req[1]    = bus.w_valid_i && (bus.w_nexthop_addr_i == N_ADDR);
    assign req[2]    = bus.e_valid_i && (bus.e_nexthop_addr_i == N_ADDR);
    assign req[3]    = bus.l_valid_i && (bus.l_nexthop_addr_i == N_ADDR);

    always_comb begin
        winner       = ptr;
        winner_found = 1'b0;
        idx          = ptr;
        for (int i = 0; i < 4; i++) begin
            idx = ptr + 2'(i);
            if (!winner_found && req[idx]) begin
                winner       = idx;
                winner_found = 1'b1;
            end
        end
    end

    assign credit_nz   = (credit_cnt != '0);
    assign fire        = (state == LOCK) && valid_vec[owner] && credit_nz;
    assign release_now = (fire && tail_vec[owner]) || wdog_expire;

    always_ff @(posedge clk) begin
        if (!reset) begin
            state      <= IDLE;
            owner      <= 2'd0;
            ptr        <= 2'd0;
            rr_pulse   <= 1'b0;
            credit_cnt <= CREDIT_MAX;
            credit_err <= 1'b0;
        end else begin
            rr_pulse <= 1'b0;
            case (state)
                IDLE: begin
                    if (winner_found && credit_nz) begin
                        owner <= winner;
                        state <= LOCK;
                    end
                end
                default: begin
                    if (release_now) begin
                        state    <= IDLE;
                        ptr      <= owner + 2'd1;
                        rr_pulse <= 1'b1;
                    end
                end
            endcase

            // simultaneous fire and return cancel out
            case ({bus.credit_return_i, fire})
                2'b10: begin
                    if (credit_cnt == CREDIT_MAX) credit_err <= 1'b1;
                    else                          credit_cnt <= credit_cnt + 1'b1;
                end
                2'b01:   credit_cnt <= credit_cnt - 1'b1;
                default: credit_cnt <= credit_cnt;
            endcase
        end
    end

`ifdef N_ALLOC_WATCHDOG_EN
    localparam int SW = $clog2(WDOG_CYCLES + 1);

    logic [SW-1:0] stall_cnt;
    logic          wdog_pulse;

    // expires on the WDOG_CYCLES-th consecutive stalled LOCK cycle
    assign wdog_expire = (state == LOCK) && !fire && (stall_cnt == SW'(WDOG_CYCLES - 1));

    always_ff @(posedge clk) begin
        if (!reset) begin
            stall_cnt  <= '0;
            wdog_pulse <= 1'b0;
        end else begin
            wdog_pulse <= wdog_expire;
            if (state != LOCK || fire || wdog_expire) stall_cnt <= '0;
            else                                      stall_cnt <= stall_cnt + 1'b1;
        end
    end

    assign bus.wdog_timeout_o = wdog_pulse;
`else
    logic wdog_param_unused;

    assign wdog_expire        = 1'b0;
    assign wdog_param_unused  = (WDOG_CYCLES == 0);
    assign bus.wdog_timeout_o = 1'b0;
`endif

    assign bus.alloc_grant_o     = (state == LOCK) ? (4'b1000 >> owner) : 4'b0000;
    assign bus.xbar_sel_o        = (state == LOCK) ? ({1'b0, owner} + 3'd1) : 3'd0;
    assign bus.flit_fire_o       = fire;
    assign bus.rr_change_order_o = rr_pulse;
    assign bus.credit_cnt_o      = credit_cnt;
    assign bus.credit_err_o      = credit_err;
    assign bus.busy_o            = (state == LOCK);
endmodule

// File: tb/tb_n_port_alloc_ctrl.sv
// Directed bench for n_port_alloc_ctrl; grants are checked against a queue of
// expected owners filled as requests are driven.
module tb_n_port_alloc_ctrl;
    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    n_port_alloc_if #(.CNT_W(3)) bus ();

    n_port_alloc_ctrl #(
        .N_ADDR(3'b000), .CREDIT_DEPTH(4), .CNT_W(3), .WDOG_CYCLES(16)
    ) dut (
        .clk(clk), .reset(reset), .bus(bus.slave)
    );

    logic [3:0] v;
    logic [3:0] t;
    logic [2:0] a [4];
    logic       cr;

    assign bus.s_valid_i        = v[0];
    assign bus.w_valid_i        = v[1];
    assign bus.e_valid_i        = v[2];
    assign bus.l_valid_i        = v[3];
    assign bus.s_tail_i         = t[0];
    assign bus.w_tail_i         = t[1];
    assign bus.e_tail_i         = t[2];
    assign bus.l_tail_i         = t[3];
    assign bus.s_nexthop_addr_i = a[0];
    assign bus.w_nexthop_addr_i = a[1];
    assign bus.e_nexthop_addr_i = a[2];
    assign bus.l_nexthop_addr_i = a[3];
    assign bus.credit_return_i  = cr;

    int vectors = 0;
    int miscompares = 0;

    typedef struct packed {
        logic [3:0] grant;
        logic [2:0] sel;
    } exp_t;
    exp_t exp_q[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input int i, input logic vv, input logic [2:0] aa, input logic tt);
        v[i] = vv;
        a[i] = aa;
        t[i] = tt;
    endtask

    task automatic push_exp(input int owner);
        exp_t e;
        e.grant = 4'b1000 >> owner;
        e.sel   = 3'(owner + 1);
        exp_q.push_back(e);
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    // scoreboard: every new grant must match the oldest expected owner
    logic [3:0] prev_grant = 4'b0000;
    always @(negedge clk) begin
        exp_t e;
        if (bus.alloc_grant_o != 4'b0000 && prev_grant == 4'b0000) begin
            if (exp_q.size() == 0) begin
                chk("grant_unexpected", 32'(bus.alloc_grant_o), 32'h0);
            end else begin
                e = exp_q.pop_front();
                chk("sb_grant", 32'(bus.alloc_grant_o), 32'(e.grant));
                chk("sb_xbar_sel", 32'(bus.xbar_sel_o), 32'(e.sel));
            end
        end
        prev_grant = bus.alloc_grant_o;
    end

    initial begin
        reset = 1'b0;
        v = 4'b0000;
        t = 4'b0000;
        cr = 1'b0;
        for (int i = 0; i < 4; i++) a[i] = 3'b111;
        tick(); tick();
        #1;
        chk("rst_grant", 32'(bus.alloc_grant_o), 32'h0);
        chk("rst_sel", 32'(bus.xbar_sel_o), 32'h0);
        chk("rst_rr", 32'(bus.rr_change_order_o), 32'h0);
        chk("rst_credit", 32'(bus.credit_cnt_o), 32'd4);
        chk("rst_err", 32'(bus.credit_err_o), 32'h0);
        chk("rst_busy", 32'(bus.busy_o), 32'h0);
        chk("rst_wdog", 32'(bus.wdog_timeout_o), 32'h0);

        // S and E request, ptr=S: S owns a 3-flit packet, then E
        reset = 1'b1;
        drive(0, 1, 3'b000, 0);
        drive(2, 1, 3'b000, 0);
        push_exp(0);
        tick(); #1;
        chk("s_fire1", 32'(bus.flit_fire_o), 32'h1);
        chk("s_busy", 32'(bus.busy_o), 32'h1);
        tick(); tick();
        drive(0, 1, 3'b000, 1);
        #1 chk("s_fire_tail", 32'(bus.flit_fire_o), 32'h1);
        tick();
        drive(0, 0, 3'b000, 0);
        drive(2, 1, 3'b000, 1);
        push_exp(2);
        #1;
        chk("s_release_rr", 32'(bus.rr_change_order_o), 32'h1);
        chk("s_release_grant", 32'(bus.alloc_grant_o), 32'h0);
        chk("s_credit", 32'(bus.credit_cnt_o), 32'd1);
        tick(); #1;
        chk("e_fire", 32'(bus.flit_fire_o), 32'h1);
        chk("e_rr_idle_in_lock", 32'(bus.rr_change_order_o), 32'h0);
        tick();
        drive(2, 0, 3'b000, 0);
        #1;
        chk("e_release_rr", 32'(bus.rr_change_order_o), 32'h1);
        chk("e_credit", 32'(bus.credit_cnt_o), 32'd0);
        cr = 1'b1;
        repeat (4) tick();
        cr = 1'b0;
        #1 chk("refill_credit", 32'(bus.credit_cnt_o), 32'd4);

        // all four request single-flit packets from ptr=S
        reset = 1'b0;
        tick();
        reset = 1'b1;
        for (int i = 0; i < 4; i++) drive(i, 1, 3'b000, 1);
        for (int k = 0; k < 5; k++) begin
            push_exp(k % 4);
            tick(); #1;
            chk("rr_fire", 32'(bus.flit_fire_o), 32'h1);
            cr = 1'b1;
            tick();
            cr = 1'b0;
            if (k == 4) v = 4'b0000;
            #1;
            chk("rr_pulse", 32'(bus.rr_change_order_o), 32'h1);
            chk("rr_idle_grant", 32'(bus.alloc_grant_o), 32'h0);
            chk("rr_credit", 32'(bus.credit_cnt_o), 32'd4);
        end

        // W sends a 6-flit packet with only 4 credits
        t = 4'b0000;
        drive(1, 1, 3'b000, 0);
        push_exp(1);
        tick();
        for (int k = 0; k < 4; k++) begin
            #1 chk("cr_fire", 32'(bus.flit_fire_o), 32'h1);
            tick();
        end
        #1;
        chk("cr_stall_cnt", 32'(bus.credit_cnt_o), 32'd0);
        chk("cr_stall_fire", 32'(bus.flit_fire_o), 32'h0);
        chk("cr_stall_grant", 32'(bus.alloc_grant_o), 32'h4);
        tick();
        cr = 1'b1;
        #1 chk("cr_stall_fire2", 32'(bus.flit_fire_o), 32'h0);
        tick();
        cr = 1'b0;
        #1;
        chk("cr_resume_cnt", 32'(bus.credit_cnt_o), 32'd1);
        chk("cr_resume_fire", 32'(bus.flit_fire_o), 32'h1);
        tick();
        #1 chk("cr_zero_again", 32'(bus.credit_cnt_o), 32'd0);
        cr = 1'b1;
        tick();
        drive(1, 1, 3'b000, 1);
        #1;
        chk("cr_pre_coincide", 32'(bus.credit_cnt_o), 32'd1);
        chk("cr_tail_fire", 32'(bus.flit_fire_o), 32'h1);
        tick();
        cr = 1'b0;
        drive(1, 0, 3'b000, 0);
        #1;
        chk("cr_coincide_cnt", 32'(bus.credit_cnt_o), 32'd1);
        chk("cr_release_rr", 32'(bus.rr_change_order_o), 32'h1);
        cr = 1'b1;
        repeat (3) tick();
        cr = 1'b0;

        // W valid but routed elsewhere, then routed north
        drive(1, 1, 3'b010, 1);
        repeat (3) tick();
        #1;
        chk("nonnorth_grant", 32'(bus.alloc_grant_o), 32'h0);
        chk("nonnorth_busy", 32'(bus.busy_o), 32'h0);
        drive(1, 1, 3'b000, 1);
        push_exp(1);
        tick(); #1;
        chk("north_grant", 32'(bus.alloc_grant_o), 32'h4);
        tick();
        drive(1, 0, 3'b000, 0);
        #1 chk("north_rr", 32'(bus.rr_change_order_o), 32'h1);
        cr = 1'b1;
        tick();
        cr = 1'b0;

        // reset in the middle of an L packet
        drive(3, 1, 3'b000, 0);
        push_exp(3);
        tick(); tick();
        reset = 1'b0;
        tick(); #1;
        chk("mid_rst_grant", 32'(bus.alloc_grant_o), 32'h0);
        chk("mid_rst_sel", 32'(bus.xbar_sel_o), 32'h0);
        chk("mid_rst_credit", 32'(bus.credit_cnt_o), 32'd4);
        chk("mid_rst_rr", 32'(bus.rr_change_order_o), 32'h0);
        chk("mid_rst_busy", 32'(bus.busy_o), 32'h0);
        reset = 1'b1;
        drive(3, 1, 3'b000, 1);
        drive(0, 1, 3'b000, 1);
        push_exp(0);
        tick(); #1;
        chk("ptr_after_rst", 32'(bus.alloc_grant_o), 32'h8);
        tick();
        v = 4'b0000;
        t = 4'b0000;
        #1 chk("ptr_rst_rr", 32'(bus.rr_change_order_o), 32'h1);
        cr = 1'b1;
        tick(); #1;
        chk("err_refill_cnt", 32'(bus.credit_cnt_o), 32'd4);
        chk("err_before", 32'(bus.credit_err_o), 32'h0);
        tick();
        cr = 1'b0;
        #1;
        chk("err_set", 32'(bus.credit_err_o), 32'h1);
        chk("err_cnt_held", 32'(bus.credit_cnt_o), 32'd4);

        // owner valid drops after its head flit
        drive(1, 1, 3'b000, 0);
        push_exp(1);
        tick(); #1;
        chk("wd_head_fire", 32'(bus.flit_fire_o), 32'h1);
        tick();
        drive(1, 0, 3'b000, 0);
`ifdef N_ALLOC_WATCHDOG_EN
        repeat (15) tick();
        #1;
        chk("wd_still_busy", 32'(bus.busy_o), 32'h1);
        chk("wd_not_yet", 32'(bus.wdog_timeout_o), 32'h0);
        tick(); #1;
        chk("wd_timeout", 32'(bus.wdog_timeout_o), 32'h1);
        chk("wd_rr", 32'(bus.rr_change_order_o), 32'h1);
        chk("wd_grant", 32'(bus.alloc_grant_o), 32'h0);
        chk("wd_credit", 32'(bus.credit_cnt_o), 32'd3);
        tick(); #1;
        chk("wd_pulse_end", 32'(bus.wdog_timeout_o), 32'h0);
`else
        repeat (40) tick();
        #1;
        chk("hold_grant", 32'(bus.alloc_grant_o), 32'h4);
        chk("hold_busy", 32'(bus.busy_o), 32'h1);
        chk("hold_wdog", 32'(bus.wdog_timeout_o), 32'h0);
`endif

        chk("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
